// File: rtl/cache_pkg.sv
// Shared constants, types and address helpers for the direct-mapped write-back cache.
package cache_pkg;

   localparam int ADDR_WIDTH = 64;
   localparam int DATA_WIDTH = 64;
   localparam int INDEX_BITS = 8;
   localparam int TAG_BITS   = ADDR_WIDTH - INDEX_BITS;
   localparam int LINES      = 1 << INDEX_BITS;

   typedef logic [INDEX_BITS-1:0] index_t;
   typedef logic [TAG_BITS-1:0]   tag_t;
   typedef logic [ADDR_WIDTH-1:0] addr_t;
   typedef logic [DATA_WIDTH-1:0] data_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOOKUP,
      S_WB_REQ,
      S_WB_WAIT,
      S_FILL_REQ,
      S_FILL_WAIT
   } state_e;

   function automatic index_t addr_index(input addr_t a);
      return a[INDEX_BITS-1:0];
   endfunction

   function automatic tag_t addr_tag(input addr_t a);
      return a[ADDR_WIDTH-1:INDEX_BITS];
   endfunction

endpackage

// File: rtl/cache_if.sv
// re/we/ready word-memory handshake shared by the upstream and downstream ports.
interface cache_if;
   import cache_pkg::*;

   addr_t addr;
   data_t din;
   data_t dout;
   logic  re;
   logic  we;
   logic  ready;

   modport master (output addr, din, re, we, input dout, ready);
   modport slave  (input addr, din, re, we, output dout, ready);

endinterface

// File: rtl/cache_tag.sv
// Tag store with valid/dirty flop vectors; compares the pending request against its line.
module cache_tag_array
   import cache_pkg::*;
(
   input  logic   clk_i,
   input  logic   rst_ni,
   input  index_t idx_i,
   input  tag_t   tag_i,
   input  logic   install_i,
   input  logic   install_dirty_i,
   output logic   hit_o,
   output logic   victim_dirty_o,
   output tag_t   victim_tag_o
);

   logic [LINES-1:0] valid_q;
   logic [LINES-1:0] dirty_q;
   tag_t             tags_q [LINES];

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (install_i) begin
         valid_q[idx_i] <= 1'b1;
         dirty_q[idx_i] <= install_dirty_i;
      end
   end

   // NOTE: storage arrays carry no reset; the valid vector alone decides whether a line means anything.
   always_ff @(posedge clk_i) begin
      if (install_i) tags_q[idx_i] <= tag_i;
   end

   assign victim_tag_o   = tags_q[idx_i];
   assign hit_o          = valid_q[idx_i] && (tags_q[idx_i] == tag_i);
   assign victim_dirty_o = valid_q[idx_i] && dirty_q[idx_i];

endmodule

// File: rtl/cache.sv
// Direct-mapped, write-back, write-allocate cache with one-word lines.
module cache
   import cache_pkg::*;
(
   input  logic     clk_i,
   input  logic     rst_ni,
   cache_if.slave   up,
   cache_if.master  mem
);

   state_e state_q;
   logic   ready_q;
   data_t  dout_q;
   addr_t  maddr_q;
   data_t  mout_q;
   logic   mre_q;
   logic   mwe_q;
   addr_t  req_addr_q;
   data_t  req_din_q;
   logic   req_we_q;

   data_t  data_q [LINES];

   index_t lookup_idx;
   tag_t   lookup_tag;
   logic   hit;
   logic   victim_dirty;
   tag_t   victim_tag;
   logic   install;
   logic   install_dirty;
   data_t  install_data;

   assign lookup_idx = addr_index(req_addr_q);
   assign lookup_tag = addr_tag(req_addr_q);

   cache_tag_array u_tag (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .idx_i           (lookup_idx),
      .tag_i           (lookup_tag),
      .install_i       (install),
      .install_dirty_i (install_dirty),
      .hit_o           (hit),
      .victim_dirty_o  (victim_dirty),
      .victim_tag_o    (victim_tag)
   );

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      install       = 1'b0;
      install_dirty = 1'b0;
      install_data  = req_din_q;
      case (state_q)
         S_LOOKUP: begin
            if (req_we_q && (hit || !victim_dirty)) begin
               install       = 1'b1;
               install_dirty = 1'b1;
            end
         end
         S_WB_WAIT: begin
            if (req_we_q && mem.ready) begin
               install       = 1'b1;
               install_dirty = 1'b1;
            end
         end
         S_FILL_WAIT: begin
            if (mem.ready) begin
               install      = 1'b1;
               install_data = mem.dout;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (install) data_q[lookup_idx] <= install_data;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q    <= S_IDLE;
         ready_q    <= 1'b1;
         dout_q     <= '0;
         maddr_q    <= '0;
         mout_q     <= '0;
         mre_q      <= 1'b0;
         mwe_q      <= 1'b0;
         req_addr_q <= '0;
         req_din_q  <= '0;
         req_we_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (up.re || up.we) begin
                  req_addr_q <= up.addr;
                  req_din_q  <= up.din;
                  req_we_q   <= up.we;
                  ready_q    <= 1'b0;
                  state_q    <= S_LOOKUP;
               end
            end
            S_LOOKUP: begin
               if (hit) begin
                  if (!req_we_q) dout_q <= data_q[lookup_idx];
                  ready_q <= 1'b1;
                  state_q <= S_IDLE;
               end else if (victim_dirty) begin
                  maddr_q <= {victim_tag, lookup_idx};
                  mout_q  <= data_q[lookup_idx];
                  mwe_q   <= 1'b1;
                  state_q <= S_WB_REQ;
               end else if (req_we_q) begin
                  ready_q <= 1'b1;
                  state_q <= S_IDLE;
               end else begin
                  maddr_q <= req_addr_q;
                  mre_q   <= 1'b1;
                  state_q <= S_FILL_REQ;
               end
            end
            S_WB_REQ: begin
               if (mem.ready) begin
                  mwe_q   <= 1'b0;
                  state_q <= S_WB_WAIT;
               end
            end
            S_WB_WAIT: begin
               // Write misses finish here; read misses chain straight into the fill.
               if (mem.ready) begin
                  if (req_we_q) begin
                     ready_q <= 1'b1;
                     state_q <= S_IDLE;
                  end else begin
                     maddr_q <= req_addr_q;
                     mre_q   <= 1'b1;
                     state_q <= S_FILL_REQ;
                  end
               end
            end
            S_FILL_REQ: begin
               if (mem.ready) begin
                  mre_q   <= 1'b0;
                  state_q <= S_FILL_WAIT;
               end
            end
            S_FILL_WAIT: begin
               if (mem.ready) begin
                  dout_q  <= mem.dout;
                  ready_q <= 1'b1;
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign up.dout   = dout_q;
   assign up.ready  = ready_q;
   assign mem.addr  = maddr_q;
   assign mem.din   = mout_q;
   assign mem.re    = mre_q;
   assign mem.we    = mwe_q;

endmodule

// File: tb/tb_cache.sv
// Scoreboard bench for cache against a behavioural word RAM with RAM_LATENCY=100.
module tb_cache;
   import cache_pkg::*;

   localparam int RAM_LATENCY = 100;

   typedef struct {
      string name;
      int    busy;
      data_t dout;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;

   cache_if up_bus ();
   cache_if mem_bus ();

   cache dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .up     (up_bus),
      .mem    (mem_bus)
   );

   always #5 clk = ~clk;

   // Behavioural RAM: the strobe cycle plus RAM_LATENCY-1 low-ready cycles occupy it for RAM_LATENCY cycles.
   data_t ram_mem [1024];
   data_t ram_dout  = '0;
   logic  ram_ready = 1'b1;
   int    ram_cnt   = 0;

   assign mem_bus.dout  = ram_dout;
   assign mem_bus.ready = ram_ready;

   function automatic data_t ram_rd(input addr_t a);
      return ram_mem[a[9:0]];
   endfunction

   always @(posedge clk) begin
      if (ram_ready) begin
         if (mem_bus.we) begin
            ram_mem[mem_bus.addr[9:0]] <= mem_bus.din;
            ram_ready <= 1'b0;
            ram_cnt   <= RAM_LATENCY - 2;
         end else if (mem_bus.re) begin
            ram_dout  <= ram_rd(mem_bus.addr);
            ram_ready <= 1'b0;
            ram_cnt   <= RAM_LATENCY - 2;
         end
      end else if (ram_cnt == 0) begin
         ram_ready <= 1'b1;
      end else begin
         ram_cnt <= ram_cnt - 1;
      end
   end

   int   n_checks = 0;
   int   n_pass   = 0;
   int   busy_cnt = 0;
   int   overlap_cnt = 0;
   exp_t sb_q [$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, want %h", name, act, exp);
   endtask

   // Monitor: measures each busy window and compares it with the queued expectation.
   always @(negedge clk) begin
      exp_t e;
      if (mem_bus.re && mem_bus.we) overlap_cnt++;
      if (rst_n !== 1'b1) begin
         busy_cnt = 0;
      end else if (up_bus.ready === 1'b0) begin
         busy_cnt++;
      end else if (busy_cnt > 0) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_completion: busy %0d cycles, nothing queued", busy_cnt);
         end else begin
            e = sb_q.pop_front();
            check({e.name, "_busy"}, 64'(busy_cnt), 64'(e.busy));
            check({e.name, "_dout"}, up_bus.dout, e.dout);
         end
         busy_cnt = 0;
      end
   end

   task automatic wait_idle(input string name);
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (up_bus.ready === 1'b1) return;
      end
      check({name, "_timeout"}, 64'(up_bus.ready), 64'd1);
   endtask

   task automatic drive(input logic r, input logic w, input addr_t a, input data_t d);
      @(posedge clk); #2;
      up_bus.re = r; up_bus.we = w; up_bus.addr = a; up_bus.din = d;
      @(posedge clk); #2;
      up_bus.re = 1'b0; up_bus.we = 1'b0;
   endtask

   task automatic issue(input string name, input logic r, input logic w, input addr_t a,
                        input data_t d, input int busy, input data_t exp_dout);
      exp_t e;
      e.name = name; e.busy = busy; e.dout = exp_dout;
      sb_q.push_back(e);
      drive(r, w, a, d);
      wait_idle(name);
   endtask

   initial begin
      exp_t e;
      for (int i = 0; i < 1024; i++) ram_mem[i] = '0;
      rst_n = 1'b0;
      up_bus.re = 1'b0; up_bus.we = 1'b0; up_bus.addr = '0; up_bus.din = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ready", 64'(up_bus.ready), 64'd1);
      check("rst_dout", up_bus.dout, 64'd0);
      check("rst_strobes", {62'd0, mem_bus.re, mem_bus.we}, 64'd0);
      check("rst_maddr", mem_bus.addr, 64'd0);
      check("rst_mout", mem_bus.din, 64'd0);
      @(posedge clk); #2 rst_n = 1'b1;

      issue("wr1_miss",    1'b0, 1'b1, 64'd1,   64'h0123456789abcdef, 1,   64'd0);
      issue("rd1_hit",     1'b1, 1'b0, 64'd1,   64'd0,                1,   64'h0123456789abcdef);
      issue("wr257_evict", 1'b0, 1'b1, 64'd257, 64'd123,              102, 64'h0123456789abcdef);
      check("ram1_wb", ram_rd(64'd1), 64'h0123456789abcdef);
      issue("rd257_hit",   1'b1, 1'b0, 64'd257, 64'd0,                1,   64'd123);
      issue("rd1_wb_fill", 1'b1, 1'b0, 64'd1,   64'd0,                203, 64'h0123456789abcdef);
      check("ram257_wb", ram_rd(64'd257), 64'd123);
      issue("wr256_clean", 1'b0, 1'b1, 64'd256, 64'd321,              1,   64'h0123456789abcdef);
      issue("rd257_fill",  1'b1, 1'b0, 64'd257, 64'd0,                102, 64'd123);
      issue("rd256_hit",   1'b1, 1'b0, 64'd256, 64'd0,                1,   64'd321);
      issue("wr1_5",       1'b0, 1'b1, 64'd1,   64'd5,                1,   64'd321);
      issue("rd1_5",       1'b1, 1'b0, 64'd1,   64'd0,                1,   64'd5);
      issue("rewe2",       1'b1, 1'b1, 64'd2,   64'd77,               1,   64'd5);
      issue("rd2_77",      1'b1, 1'b0, 64'd2,   64'd0,                1,   64'd77);

      // Read miss with writeback; a write presented while busy must be ignored.
      e.name = "rd513_busy"; e.busy = 203; e.dout = 64'd0;
      sb_q.push_back(e);
      drive(1'b1, 1'b0, 64'd513, 64'd0);
      repeat (10) @(posedge clk);
      drive(1'b0, 1'b1, 64'd2, 64'd999);
      wait_idle("rd513_busy");
      check("ram1_wb5", ram_rd(64'd1), 64'd5);
      issue("rd2_ignored", 1'b1, 1'b0, 64'd2,   64'd0,                1,   64'd77);

      // Reset in the middle of a dirty read miss.
      drive(1'b1, 1'b0, 64'd258, 64'd0);
      repeat (20) @(posedge clk);
      #2 rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("midrst_ready", 64'(up_bus.ready), 64'd1);
      check("midrst_dout", up_bus.dout, 64'd0);
      check("midrst_strobes", {62'd0, mem_bus.re, mem_bus.we}, 64'd0);
      @(posedge clk); #2 rst_n = 1'b1;
      repeat (150) @(posedge clk);

      issue("rd256_inval", 1'b1, 1'b0, 64'd256, 64'd0,                102, 64'd0);
      issue("rd513_inval", 1'b1, 1'b0, 64'd513, 64'd0,                102, 64'd0);

      repeat (2) @(negedge clk);
      check("strobe_overlap", 64'(overlap_cnt), 64'd0);
      check("sb_drained", 64'(sb_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
